// File: rtl/packet_injector.sv
// Byte-serial packet source for the 1x3 router write port: header, payload, XOR parity,
// then an enforced inter-packet gap, all subject to the router's stop_packet backpressure.
module packet_injector #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_dest,
    input  logic [5:0]           cmd_len,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 stop_packet,
    output logic [7:0]           packet_out,
    output logic                 packet_valid_o,
    output logic                 pkt_done,
    output logic                 err_cmd,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StPayload, StParity, StGap} state_e;

    state_e               r_state, w_state;
    logic [7:0]           r_out, w_out;
    logic                 r_valid, w_valid;
    logic                 r_done, w_done;
    logic                 r_err, w_err;
    logic [CNT_WIDTH-1:0] r_pkt_cnt, w_pkt_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt, w_stall_cnt;
    logic [7:0]           r_parity, w_parity;
    logic [5:0]           r_remaining, w_remaining;
    logic [GapW-1:0]      r_gap_cnt, w_gap_cnt;
    logic                 w_cmd_ready, w_in_ready, w_stalled, w_illegal;

    assign w_illegal = (cmd_dest == 2'd0) || (cmd_len == 6'd0);

    always_comb begin
        w_state     = r_state;
        w_out       = r_out;
        w_valid     = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_pkt_cnt   = r_pkt_cnt;
        w_stall_cnt = r_stall_cnt;
        w_parity    = r_parity;
        w_remaining = r_remaining;
        w_gap_cnt   = r_gap_cnt;
        w_cmd_ready = 1'b0;
        w_in_ready  = 1'b0;
        w_stalled   = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_cmd_ready = !stop_packet;
                w_stalled   = cmd_valid && stop_packet;
                // Illegal commands are rejected even under backpressure: nothing is emitted.
                if (cmd_valid && w_illegal) begin
                    w_err = 1'b1;
                end else if (cmd_valid && !stop_packet) begin
                    w_out       = {cmd_len, cmd_dest};
                    w_valid     = 1'b1;
                    w_parity    = {cmd_len, cmd_dest};
                    w_remaining = cmd_len;
                    w_state     = StPayload;
                end
            end
            StPayload: begin
                w_in_ready = !stop_packet;
                w_stalled  = in_valid && stop_packet;
                if (in_valid && !stop_packet) begin
                    w_out       = in_data;
                    w_valid     = 1'b1;
                    w_parity    = r_parity ^ in_data;
                    w_remaining = r_remaining - 6'd1;
                    if (r_remaining == 6'd1) begin
                        w_state = StParity;
                    end
                end
            end
            StParity: begin
                w_stalled = stop_packet;
                if (!stop_packet) begin
                    w_out     = r_parity;
                    w_valid   = 1'b1;
                    w_done    = 1'b1;
                    w_pkt_cnt = r_pkt_cnt + CNT_WIDTH'(1);
                    if (GAP_CYCLES == 0) begin
                        w_state = StIdle;
                    end else begin
                        w_state   = StGap;
                        w_gap_cnt = GapW'(GAP_CYCLES - 1);
                    end
                end
            end
            StGap: begin
                if (r_gap_cnt == '0) begin
                    w_state = StIdle;
                end else begin
                    w_gap_cnt = r_gap_cnt - GapW'(1);
                end
            end
            default: w_state = StIdle;
        endcase

        if (w_stalled) begin
            w_stall_cnt = r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_out       <= 8'h00;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
            r_parity    <= 8'h00;
            r_remaining <= 6'd0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state;
            r_out       <= w_out;
            r_valid     <= w_valid;
            r_done      <= w_done;
            r_err       <= w_err;
            r_pkt_cnt   <= w_pkt_cnt;
            r_stall_cnt <= w_stall_cnt;
            r_parity    <= w_parity;
            r_remaining <= w_remaining;
            r_gap_cnt   <= w_gap_cnt;
        end
    end

    assign cmd_ready      = w_cmd_ready;
    assign in_ready       = w_in_ready;
    assign packet_out     = r_out;
    assign packet_valid_o = r_valid;
    assign pkt_done       = r_done;
    assign err_cmd        = r_err;
    assign pkt_count      = r_pkt_cnt;
    assign stall_count    = r_stall_cnt;

endmodule

// File: tb/tb_packet_injector.sv
// Bench for packet_injector: directed scenarios plus randomized traffic checked against a
// byte-stream model (header, payload, XOR parity per packet).
module tb_packet_injector;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cmd_valid, in_valid, stop_packet, sel;
    logic [1:0] cmd_dest;
    logic [5:0] cmd_len;
    logic [7:0] in_data;

    logic        a_cmd_ready, a_in_ready, a_valid, a_done, a_err;
    logic [7:0]  a_out;
    logic [15:0] a_pkt, a_stall;
    logic        b_cmd_ready, b_in_ready, b_valid, b_done, b_err;
    logic [7:0]  b_out;
    logic [15:0] b_pkt, b_stall;

    logic cv_a, cv_b, iv_a, iv_b;
    assign cv_a = cmd_valid & ~sel;
    assign cv_b = cmd_valid & sel;
    assign iv_a = in_valid & ~sel;
    assign iv_b = in_valid & sel;

    packet_injector #(.GAP_CYCLES(1), .CNT_WIDTH(16)) u_dut_gap1 (
        .clk(clk), .rst(rst), .cmd_valid(cv_a), .cmd_ready(a_cmd_ready),
        .cmd_dest(cmd_dest), .cmd_len(cmd_len), .in_data(in_data), .in_valid(iv_a),
        .in_ready(a_in_ready), .stop_packet(stop_packet), .packet_out(a_out),
        .packet_valid_o(a_valid), .pkt_done(a_done), .err_cmd(a_err),
        .pkt_count(a_pkt), .stall_count(a_stall)
    );

    packet_injector #(.GAP_CYCLES(0), .CNT_WIDTH(16)) u_dut_gap0 (
        .clk(clk), .rst(rst), .cmd_valid(cv_b), .cmd_ready(b_cmd_ready),
        .cmd_dest(cmd_dest), .cmd_len(cmd_len), .in_data(in_data), .in_valid(iv_b),
        .in_ready(b_in_ready), .stop_packet(stop_packet), .packet_out(b_out),
        .packet_valid_o(b_valid), .pkt_done(b_done), .err_cmd(b_err),
        .pkt_count(b_pkt), .stall_count(b_stall)
    );

    logic        m_cmd_ready, m_in_ready, m_valid, m_done, m_err;
    logic [7:0]  m_out;
    logic [15:0] m_pkt, m_stall;
    assign m_cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
    assign m_in_ready  = sel ? b_in_ready : a_in_ready;
    assign m_valid     = sel ? b_valid : a_valid;
    assign m_done      = sel ? b_done : a_done;
    assign m_err       = sel ? b_err : a_err;
    assign m_out       = sel ? b_out : a_out;
    assign m_pkt       = sel ? b_pkt : a_pkt;
    assign m_stall     = sel ? b_stall : a_stall;

    int vectors = 0;
    int miscompares = 0;
    int exp_pkt = 0;
    int exp_stall = 0;

    bq_t  obs_q, exp_q;
    bit   done_q[$], exp_done_q[$];
    int   t_q[$];
    bit   rdy_hist[int];
    int   cyc, err_seen, both_ready, done_wo_valid;

    // Sampled mid-low-phase, after the driver has settled its inputs for the cycle.
    initial begin
        cyc = 0; err_seen = 0; both_ready = 0; done_wo_valid = 0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            rdy_hist[cyc] = m_cmd_ready;
            if (m_valid) begin
                obs_q.push_back(m_out);
                done_q.push_back(m_done);
                t_q.push_back(cyc);
            end else if (m_done) begin
                done_wo_valid++;
            end
            if (m_err) err_seen++;
            if (m_cmd_ready && m_in_ready) both_ready++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic clear_obs();
        obs_q.delete(); done_q.delete(); t_q.delete();
        exp_q.delete(); exp_done_q.delete();
    endtask

    task automatic expect_pkt(input logic [1:0] d, input logic [5:0] l, input bq_t pl);
        logic [7:0] p;
        p = {l, d};
        exp_q.push_back(p);
        exp_done_q.push_back(1'b0);
        foreach (pl[i]) begin
            exp_q.push_back(pl[i]);
            exp_done_q.push_back(1'b0);
            p = p ^ pl[i];
        end
        exp_q.push_back(p);
        exp_done_q.push_back(1'b1);
        exp_pkt++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            stop_packet = 1'b0;
        end
    endtask

    task automatic offer_cmd(input logic [1:0] d, input logic [5:0] l, input bit rnd);
        int n = 0;
        bit got = 0;
        cmd_valid = 1'b1; cmd_dest = d; cmd_len = l;
        while (!got && n < 400) begin
            stop_packet = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            #1;
            got = m_cmd_ready;
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0; stop_packet = 1'b0;
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL cmd_accept: cmd_ready=0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit rnd);
        int n = 0;
        bit got = 0;
        in_data = b;
        while (!got && n < 400) begin
            in_valid    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            stop_packet = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
            #1;
            got = in_valid && m_in_ready;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0; stop_packet = 1'b0;
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL byte_accept: in_ready=0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; sel = 1'b0; cmd_valid = 1'b0; in_valid = 1'b0; stop_packet = 1'b0;
        cmd_dest = 2'd0; cmd_len = 6'd0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (m_valid !== 1'b0 || m_out !== 8'h00 || m_done !== 1'b0 || m_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b out=%h done=%b err=%b, required 0 0 0 0",
                     m_valid, m_out, m_done, m_err);
        end
        vectors++;
        if (m_pkt !== 16'd0 || m_stall !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_counters: pkt=%0d stall=%0d, required 0 0", m_pkt, m_stall);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (m_cmd_ready !== 1'b1 || m_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: cmd_ready=%b in_ready=%b, required 1 0",
                     m_cmd_ready, m_in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        bq_t pl;
        clear_obs();
        pl = {8'hA5, 8'h3C, 8'h0F};
        expect_pkt(2'd2, 6'd3, pl);
        offer_cmd(2'd2, 6'd3, 1'b0);
        foreach (pl[i]) push_byte(pl[i], 1'b0);
        idle(4);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL basic_count: got %0d bytes, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                vectors++;
                if (obs_q[i] !== exp_q[i] || done_q[i] !== exp_done_q[i]) begin
                    miscompares++;
                    $display("FAIL basic_byte[%0d]: got %02h done=%0b, expected %02h done=%0b",
                             i, obs_q[i], done_q[i], exp_q[i], exp_done_q[i]);
                end
            end
            vectors++;
            if (obs_q[0] !== 8'h0E || obs_q[4] !== 8'h98) begin
                miscompares++;
                $display("FAIL basic_literal: header=%02h parity=%02h, expected 0e 98",
                         obs_q[0], obs_q[4]);
            end
            vectors++;
            if (t_q[4] - t_q[0] != 4) begin
                miscompares++;
                $display("FAIL basic_consecutive: span=%0d, expected 4", t_q[4] - t_q[0]);
            end
            vectors++;
            if (rdy_hist[t_q[4]] !== 1'b0 || rdy_hist[t_q[4] + 1] !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_gap: cmd_ready at parity=%b next=%b, expected 0 1",
                         rdy_hist[t_q[4]], rdy_hist[t_q[4] + 1]);
            end
        end
        vectors++;
        if (m_pkt !== 16'(exp_pkt)) begin
            miscompares++;
            $display("FAIL basic_pkt_count: got %0d, expected %0d", m_pkt, exp_pkt);
        end
    endtask

    task automatic test_stall();
        bq_t pl;
        clear_obs();
        pl = {8'hA5, 8'h3C, 8'h0F};
        expect_pkt(2'd2, 6'd3, pl);
        offer_cmd(2'd2, 6'd3, 1'b0);
        push_byte(pl[0], 1'b0);
        push_byte(pl[1], 1'b0);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = pl[2]; stop_packet = 1'b1;
            #1;
            vectors++;
            if (m_in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_in_ready[%0d]: got %b, expected 0", k, m_in_ready);
            end
            @(negedge clk);
        end
        exp_stall += 4;
        push_byte(pl[2], 1'b0);
        idle(4);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL stall_count_bytes: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                vectors++;
                if (obs_q[i] !== exp_q[i] || done_q[i] !== exp_done_q[i]) begin
                    miscompares++;
                    $display("FAIL stall_byte[%0d]: got %02h done=%0b, expected %02h done=%0b",
                             i, obs_q[i], done_q[i], exp_q[i], exp_done_q[i]);
                end
            end
            vectors++;
            if (t_q[3] - t_q[2] != 5 || t_q[4] - t_q[3] != 1) begin
                miscompares++;
                $display("FAIL stall_timing: gaps=%0d,%0d, expected 5,1",
                         t_q[3] - t_q[2], t_q[4] - t_q[3]);
            end
        end
        vectors++;
        if (m_stall !== 16'(exp_stall) || m_pkt !== 16'(exp_pkt)) begin
            miscompares++;
            $display("FAIL stall_counters: stall=%0d pkt=%0d, expected %0d %0d",
                     m_stall, m_pkt, exp_stall, exp_pkt);
        end
    endtask

    task automatic test_bubble();
        bq_t pl;
        clear_obs();
        for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
        expect_pkt(2'd1, 6'd4, pl);
        offer_cmd(2'd1, 6'd4, 1'b0);
        push_byte(pl[0], 1'b0);
        push_byte(pl[1], 1'b0);
        idle(2);
        push_byte(pl[2], 1'b0);
        push_byte(pl[3], 1'b0);
        idle(4);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL bubble_count: got %0d bytes, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                vectors++;
                if (obs_q[i] !== exp_q[i] || done_q[i] !== exp_done_q[i]) begin
                    miscompares++;
                    $display("FAIL bubble_byte[%0d]: got %02h done=%0b, expected %02h done=%0b",
                             i, obs_q[i], done_q[i], exp_q[i], exp_done_q[i]);
                end
            end
            vectors++;
            if (t_q[3] - t_q[2] != 3) begin
                miscompares++;
                $display("FAIL bubble_timing: gap=%0d, expected 3", t_q[3] - t_q[2]);
            end
        end
    endtask

    task automatic test_illegal();
        int e0;
        clear_obs();
        e0 = err_seen;
        offer_cmd(2'd0, 6'd5, 1'b0);
        offer_cmd(2'd1, 6'd0, 1'b0);
        idle(3);
        vectors++;
        if (err_seen - e0 != 2) begin
            miscompares++;
            $display("FAIL illegal_err: got %0d pulses, expected 2", err_seen - e0);
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL illegal_emit: got %0d bytes, expected 0", obs_q.size());
        end
        vectors++;
        if (m_pkt !== 16'(exp_pkt)) begin
            miscompares++;
            $display("FAIL illegal_pkt_count: got %0d, expected %0d", m_pkt, exp_pkt);
        end
    endtask

    task automatic test_back_to_back();
        bq_t p1, p2;
        int save_pkt;
        save_pkt = exp_pkt;
        exp_pkt = 0;
        sel = 1'b1;
        clear_obs();
        p1 = {8'hFF};
        for (int i = 0; i < 63; i++) p2.push_back(8'($urandom));
        expect_pkt(2'd1, 6'd1, p1);
        expect_pkt(2'd3, 6'd63, p2);
        offer_cmd(2'd1, 6'd1, 1'b0);
        push_byte(p1[0], 1'b0);
        offer_cmd(2'd3, 6'd63, 1'b0);
        foreach (p2[i]) push_byte(p2[i], 1'b0);
        idle(4);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d bytes, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                vectors++;
                if (obs_q[i] !== exp_q[i] || done_q[i] !== exp_done_q[i]) begin
                    miscompares++;
                    $display("FAIL b2b_byte[%0d]: got %02h done=%0b, expected %02h done=%0b",
                             i, obs_q[i], done_q[i], exp_q[i], exp_done_q[i]);
                end
            end
            vectors++;
            if (obs_q[0] !== 8'h05 || obs_q[1] !== 8'hFF || obs_q[2] !== 8'hFA ||
                obs_q[3] !== 8'hFF) begin
                miscompares++;
                $display("FAIL b2b_literal: %02h %02h %02h %02h, expected 05 ff fa ff",
                         obs_q[0], obs_q[1], obs_q[2], obs_q[3]);
            end
            vectors++;
            if (t_q[3] - t_q[2] != 1 || t_q[67] - t_q[0] != 67) begin
                miscompares++;
                $display("FAIL b2b_timing: hdr-after-parity=%0d span=%0d, expected 1 67",
                         t_q[3] - t_q[2], t_q[67] - t_q[0]);
            end
        end
        vectors++;
        if (m_pkt !== 16'd2) begin
            miscompares++;
            $display("FAIL b2b_pkt_count: got %0d, expected 2", m_pkt);
        end
        sel = 1'b0;
        exp_pkt = save_pkt;
    endtask

    task automatic test_reset_mid();
        bq_t pl, p2;
        clear_obs();
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
        offer_cmd(2'd2, 6'd10, 1'b0);
        for (int i = 0; i < 4; i++) push_byte(pl[i], 1'b0);
        #3;
        rst = 1'b0;
        #1;
        vectors++;
        if (m_valid !== 1'b0 || m_out !== 8'h00 || m_done !== 1'b0 || m_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs: valid=%b out=%h done=%b err=%b, required 0 0 0 0",
                     m_valid, m_out, m_done, m_err);
        end
        vectors++;
        if (m_pkt !== 16'd0 || m_stall !== 16'd0 || m_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state: pkt=%0d stall=%0d in_ready=%b, required 0 0 0",
                     m_pkt, m_stall, m_in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_pkt = 0;
        exp_stall = 0;
        clear_obs();
        for (int i = 0; i < 7; i++) p2.push_back(8'($urandom));
        expect_pkt(2'd3, 6'd7, p2);
        offer_cmd(2'd3, 6'd7, 1'b0);
        foreach (p2[i]) push_byte(p2[i], 1'b0);
        idle(4);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL midrst_count: got %0d bytes, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                vectors++;
                if (obs_q[i] !== exp_q[i] || done_q[i] !== exp_done_q[i]) begin
                    miscompares++;
                    $display("FAIL midrst_byte[%0d]: got %02h done=%0b, expected %02h done=%0b",
                             i, obs_q[i], done_q[i], exp_q[i], exp_done_q[i]);
                end
            end
        end
        vectors++;
        if (m_pkt !== 16'(exp_pkt)) begin
            miscompares++;
            $display("FAIL midrst_pkt_count: got %0d, expected %0d", m_pkt, exp_pkt);
        end
    endtask

    task automatic test_random();
        int e0, n_bad;
        e0 = err_seen;
        n_bad = 0;
        clear_obs();
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) offer_cmd(2'd0, 6'($urandom_range(0, 63)), 1'b0);
                else offer_cmd(2'($urandom_range(0, 3)), 6'd0, 1'b0);
                n_bad++;
            end else begin
                bq_t pl;
                logic [1:0] d;
                logic [5:0] l;
                d = 2'($urandom_range(1, 3));
                l = (k % 8 == 3) ? 6'd63 : 6'($urandom_range(1, 12));
                for (int i = 0; i < int'(l); i++) pl.push_back(8'($urandom));
                expect_pkt(d, l, pl);
                offer_cmd(d, l, 1'b1);
                foreach (pl[i]) push_byte(pl[i], 1'b1);
            end
        end
        idle(6);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count: got %0d bytes, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                vectors++;
                if (obs_q[i] !== exp_q[i] || done_q[i] !== exp_done_q[i]) begin
                    miscompares++;
                    $display("FAIL rand_byte[%0d]: got %02h done=%0b, expected %02h done=%0b",
                             i, obs_q[i], done_q[i], exp_q[i], exp_done_q[i]);
                end
            end
        end
        vectors++;
        if (m_pkt !== 16'(exp_pkt)) begin
            miscompares++;
            $display("FAIL rand_pkt_count: got %0d, expected %0d", m_pkt, exp_pkt);
        end
        vectors++;
        if (err_seen - e0 != n_bad) begin
            miscompares++;
            $display("FAIL rand_err: got %0d pulses, expected %0d", err_seen - e0, n_bad);
        end
        vectors++;
        if (both_ready != 0 || done_wo_valid != 0) begin
            miscompares++;
            $display("FAIL invariants: both_ready=%0d done_without_valid=%0d, expected 0 0",
                     both_ready, done_wo_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_bubble();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
